// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  function automatic bit cla_width_ok(input int width, input int block);
    return (block >= 1) && (block <= 8) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice; c_msb is the carry into the top bit.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             acc;
  logic             pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products over the block, not a ripple chain.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s     = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one lookahead block per stage; result NBLK cycles after capture.
// Global stall: all stages advance only when the output register is empty or being taken.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  if (!cla_width_ok(WIDTH, BLOCK)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK and BLOCK must be 1..8");
  end

  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    // r_q: resolved sum bits below block k, still-pending A bits from block k up.
    localparam int HI = WIDTH - k * BLOCK;

    logic             vld_q;
    logic [WIDTH-1:0] r_q;
    logic [HI-1:0]    b_q;
    logic             c_q;
    logic [BLOCK-1:0] bs;
    logic             co;
    logic             cm;
    logic [WIDTH-1:0] r_nxt;

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (r_q[k*BLOCK +: BLOCK]),
      .b    (b_q[BLOCK-1:0]),
      .ci   (c_q),
      .s    (bs),
      .co   (co),
      .c_msb(cm)
    );

    always_comb begin
      r_nxt                  = r_q;
      r_nxt[k*BLOCK +: BLOCK] = bs;
    end

    if (k < NBLK - 1) begin : g_mid
      logic cm_unused;
      assign cm_unused = cm;
    end

    if (k == 0) begin : g_head
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          r_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
        end else if (en) begin
          vld_q <= accept;
          r_q   <= a;
          b_q   <= (op == OP_SUB) ? ~b : b;
          c_q   <= (op == OP_SUB) ? 1'b1 : cin;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          r_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
        end else if (en) begin
          vld_q <= g_stg[k-1].vld_q;
          r_q   <= g_stg[k-1].r_nxt;
          b_q   <= g_stg[k-1].b_q[HI+BLOCK-1:BLOCK];
          c_q   <= g_stg[k-1].co;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= g_stg[NBLK-1].vld_q;
      sum       <= g_stg[NBLK-1].r_nxt;
      cout      <= g_stg[NBLK-1].co;
      ovf       <= g_stg[NBLK-1].co ^ g_stg[NBLK-1].cm;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomized bench for pipelined_cla_adder (16/4 and 5/5) against an integer-arithmetic model.
module tb_pipelined_cla_adder;
  import adder_pkg::*;

  localparam int W    = 16;
  localparam int NBLK = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         in_valid5, in_ready5, cin5, op5, out_valid5, out_ready5, cout5, ovf5;
  logic [4:0]   a5, b5, sum5;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(5), .BLOCK(5)) u_dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid5), .in_ready(in_ready5),
    .a(a5), .b(b5), .cin(cin5), .op(op5),
    .out_valid(out_valid5), .out_ready(out_ready5), .sum(sum5), .cout(cout5), .ovf(ovf5)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  int   tests_run = 0;
  int   fails     = 0;
  res_t exp_q[$];

  // Unsigned result/carry from plain integer sums; overflow from the signed range.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic o);
    res_t r;
    int   ures;
    int   sres;
    if (o) begin
      ures   = int'(x) - int'(y);
      r.cout = (x >= y);
      sres   = int'($signed(x)) - int'($signed(y));
    end else begin
      ures   = int'(x) + int'(y) + int'(ci);
      r.cout = (ures > 65535);
      sres   = int'($signed(x)) + int'($signed(y)) + int'(ci);
    end
    r.sum = ures[W-1:0];
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD;
  endtask

  task automatic rand_op();
    in_valid = 1'b1;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    op  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++; if ({sum, cout, ovf} !== '0) begin fails++; $display("FAIL reset_outputs: got %h/%b/%b want 0", sum, cout, ovf); end
    tests_run++; if (out_valid5 !== 1'b0) begin fails++; $display("FAIL reset_out_valid5: got %b want 0", out_valid5); end
    tick();
    reset = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_carry();
    int n;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0; op = OP_ADD;
    tick();
    idle();
    n = 0;
    while (!out_valid && n < 12) begin tick(); n++; end
    tests_run++; if (n !== NBLK) begin fails++; $display("FAIL carry_latency: got %0d want %0d", n, NBLK); end
    tests_run++; if ({sum, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
      fails++; $display("FAIL carry_result: got %h/%b/%b want 0000/1/0", sum, cout, ovf);
    end
    tick();
  endtask

  task automatic test_sub_overflow();
    logic [W-1:0] ta [2];
    logic [W-1:0] tb [2];
    logic [W+1:0] te [2];
    int n;
    ta[0] = 16'h8000; tb[0] = 16'h0001; te[0] = {16'h7FFF, 1'b1, 1'b1};
    ta[1] = 16'h0000; tb[1] = 16'h0001; te[1] = {16'hFFFF, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = 1'b1; op = OP_SUB;
      tick();
      idle();
      n = 0;
      while (!out_valid && n < 12) begin tick(); n++; end
      tests_run++; if (n !== NBLK) begin fails++; $display("FAIL sub%0d_latency: got %0d want %0d", i, n, NBLK); end
      tests_run++; if ({sum, cout, ovf} !== te[i]) begin
        fails++; $display("FAIL sub%0d_result: got %h/%b/%b want %h/%b/%b", i, sum, cout, ovf,
                          te[i][W+1:2], te[i][1], te[i][0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0, got = 0, gaps = 0, cyc = 0;
    res_t r;
    exp_q.delete();
    out_ready = 1'b1;
    while ((sent < 200 || exp_q.size() > 0) && cyc < 400) begin
      if (sent < 200) rand_op(); else idle();
      #1;
      if (got > 0 && got < 200 && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++; fails++; $display("FAIL stream_extra: got unexpected %h want none", sum);
        end else begin
          r = exp_q.pop_front(); got++;
          tests_run++; if ({sum, cout, ovf} !== r) begin
            fails++; $display("FAIL stream_result #%0d: got %h/%b/%b want %h/%b/%b", got, sum, cout, ovf, r.sum, r.cout, r.ovf);
          end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(a, b, cin, op)); sent++; end
      tick();
      cyc++;
    end
    idle();
    tests_run++; if (got !== 200) begin fails++; $display("FAIL stream_count: got %0d want 200", got); end
    tests_run++; if (gaps !== 0) begin fails++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_backpressure();
    int   acc = 0, got = 0;
    res_t snap, r;
    exp_q.delete();
    out_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      rand_op();
      #1;
      if (in_ready) begin exp_q.push_back(model(a, b, cin, op)); acc++; end
      else break;
      tick();
    end
    tests_run++; if (acc !== NBLK + 1) begin fails++; $display("FAIL bp_fill: got %0d accepted want %0d", acc, NBLK + 1); end
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    snap = '{sum: sum, cout: cout, ovf: ovf};
    for (int n = 0; n < 5; n++) begin
      rand_op();
      tick();
      tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || {sum, cout, ovf} !== snap) begin
        fails++; $display("FAIL bp_hold%0d: got rdy=%b vld=%b %h want rdy=0 vld=1 %h", n, in_ready, out_valid, sum, snap.sum);
      end
    end
    idle();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests_run++; fails++; $display("FAIL bp_extra: got unexpected %h want none", sum);
        end else begin
          r = exp_q.pop_front(); got++;
          tests_run++; if ({sum, cout, ovf} !== r) begin
            fails++; $display("FAIL bp_result #%0d: got %h/%b/%b want %h/%b/%b", got, sum, cout, ovf, r.sum, r.cout, r.ovf);
          end
        end
      end
      tick();
    end
    tests_run++; if (got !== NBLK + 1) begin fails++; $display("FAIL bp_count: got %0d want %0d", got, NBLK + 1); end
  endtask

  task automatic test_random_flow();
    res_t r;
    exp_q.delete();
    for (int n = 0; n < 340; n++) begin
      if (n < 300 && $urandom_range(0, 9) < 7) rand_op(); else idle();
      out_ready = (n >= 300) || ($urandom_range(0, 9) < 6);
      #1;
      tests_run++; if (in_ready !== (!out_valid || out_ready)) begin
        fails++; $display("FAIL flow_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++; fails++; $display("FAIL flow_extra: got unexpected %h want none", sum);
        end else begin
          r = exp_q.pop_front();
          tests_run++; if ({sum, cout, ovf} !== r) begin
            fails++; $display("FAIL flow_result: got %h/%b/%b want %h/%b/%b", sum, cout, ovf, r.sum, r.cout, r.ovf);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, op));
      tick();
    end
    idle();
    tests_run++; if (exp_q.size() !== 0) begin fails++; $display("FAIL flow_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0, n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_op(); tick(); end
    idle();
    reset = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || {sum, cout, ovf} !== '0) begin
      fails++; $display("FAIL midreset_clear: got vld=%b rdy=%b %h/%b/%b want 0", out_valid, in_ready, sum, cout, ovf);
    end
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) stale++; end
    tests_run++; if (stale !== 0) begin fails++; $display("FAIL midreset_stale: got %0d outputs want 0", stale); end
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; op = OP_ADD;
    tick();
    idle();
    n = 0;
    while (!out_valid && n < 12) begin tick(); n++; end
    tests_run++; if (n !== NBLK || {sum, cout, ovf} !== {16'h2345, 1'b0, 1'b0}) begin
      fails++; $display("FAIL midreset_next: got lat=%0d %h/%b/%b want lat=%0d 2345/0/0", n, sum, cout, ovf, NBLK);
    end
    tick();
  endtask

  task automatic test_width5();
    int n;
    out_ready5 = 1'b1;
    in_valid5 = 1'b1; a5 = 5'h1F; b5 = 5'h01; cin5 = 1'b1; op5 = OP_ADD;
    #1;
    tests_run++; if (in_ready5 !== 1'b1) begin fails++; $display("FAIL w5_in_ready: got %b want 1", in_ready5); end
    tick();
    in_valid5 = 1'b0;
    n = 0;
    while (!out_valid5 && n < 12) begin tick(); n++; end
    tests_run++; if (n !== 1) begin fails++; $display("FAIL w5_latency: got %0d want 1", n); end
    tests_run++; if ({sum5, cout5, ovf5} !== {5'h01, 1'b1, 1'b0}) begin
      fails++; $display("FAIL w5_result: got %h/%b/%b want 01/1/0", sum5, cout5, ovf5);
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle();
    in_valid5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0; op5 = OP_ADD; out_ready5 = 1'b0;
    #12;
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_midstream();
    test_width5();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
